// File: rtl/program_mem.sv
// program_mem: 2048x16 program/data memory with a host image loader on the stack core's bus
// Ports: clk/rst (async active-low); mem_addr/mem_write/mem_data = core bus, read combinationally
// and written on the clock edge in RUN only; ld_start/ld_len/ld_valid/ld_data/ld_ready = host load
// stream starting at address 0; core_rst holds the core in reset outside RUN; busy marks LOAD.
module program_mem #(
  parameter int DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] mem_addr,
  input  logic        mem_write,
  inout  wire  [15:0] mem_data,
  input  logic        ld_start,
  input  logic [11:0] ld_len,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  output logic        core_rst,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t      state, state_d;
  logic [10:0] ld_addr, addr_d;
  logic [11:0] ld_remaining, rem_d;
  logic [15:0] mem [DEPTH];
  logic        drive_en;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      ld_addr      <= '0;
      ld_remaining <= '0;
    end else begin
      state        <= state_d;
      ld_addr      <= addr_d;
      ld_remaining <= rem_d;
    end
  // ld_start is honoured from IDLE and RUN alike; a zero length goes (or stays) straight to RUN
  always_comb begin
    state_d = state;
    addr_d  = ld_addr;
    rem_d   = ld_remaining;
    if (state == LOAD) begin
      if (ld_valid) begin
        addr_d  = ld_addr + 11'd1;
        rem_d   = ld_remaining - 12'd1;
        state_d = ld_remaining == 12'd1 ? RUN : LOAD;
      end
    end else if (ld_start) begin
      state_d = ld_len == 12'd0 ? RUN : LOAD;
      addr_d  = '0;
      rem_d   = ld_len > 12'(DEPTH) ? 12'(DEPTH) : ld_len;
    end
  end
  // the array has no reset so an image survives a reset pulse
  always_ff @(posedge clk)
    if (state == LOAD && ld_valid) mem[ld_addr] <= ld_data;
    else if (state == RUN && mem_write) mem[mem_addr] <= mem_data;
  assign drive_en = state == RUN && !mem_write;
  assign mem_data = drive_en ? mem[mem_addr] : 16'bz;
  assign busy     = state == LOAD;
  assign ld_ready = busy;
  assign core_rst = state != RUN;
endmodule

// File: tb/tb_program_mem.sv
// tb_program_mem: randomized self-checking bench for program_mem against an array model
module tb_program_mem;
  logic        clk = 0;
  logic        rst = 0;
  logic [10:0] mem_addr = '0;
  logic        mem_write = 0;
  logic        ld_start = 0;
  logic [11:0] ld_len = '0;
  logic        ld_valid = 0;
  logic [15:0] ld_data = '0;
  logic        tb_en = 0;
  logic [15:0] tb_val = '0;
  wire  [15:0] bus;
  logic        ld_ready, core_rst, busy;
  logic [15:0] model [2048];
  logic [15:0] preset [$];
  int          checks = 0;
  int          passed = 0;

  assign bus = tb_en ? tb_val : 16'bz;

  program_mem dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_write(mem_write), .mem_data(bus),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .core_rst(core_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  // Host load: words are written to 0..n-1 where n = min(len, 2048); the block must be in
  // LOAD (ready, core held in reset) for every word and stall cycle, then RUN afterwards.
  task automatic load(input int len, input int stall_at, input int stall_n, input bit core_wr);
    int n = len > 2048 ? 2048 : len;
    int bcnt = 0;
    logic [15:0] d;
    @(negedge clk);
    ld_start = 1;
    ld_len = 12'(len);
    @(negedge clk);
    ld_start = 0;
    if (core_wr) begin
      mem_addr = 11'h400;
      mem_write = 1;
      tb_en = 1;
      tb_val = ~model[11'h400];
    end
    for (int i = 0; i < n; i++) begin
      if (i == stall_at)
        repeat (stall_n) begin
          ld_valid = 0;
          #1;
          bcnt += int'(busy);
          checks++; if ({ld_ready, core_rst} !== 2'b11) $display("FAIL load_stall ready/core_rst got %b want 11", {ld_ready, core_rst}); else passed++;
          @(negedge clk);
        end
      if (preset.size() > 0) d = preset.pop_front();
      else d = 16'($urandom);
      ld_valid = 1;
      ld_data = d;
      #1;
      bcnt += int'(busy);
      checks++; if ({ld_ready, core_rst} !== 2'b11) $display("FAIL load_word %0d ready/core_rst got %b want 11", i, {ld_ready, core_rst}); else passed++;
      model[i] = d;
      @(negedge clk);
    end
    ld_valid = 0;
    mem_write = 0;
    tb_en = 0;
    #1;
    checks++; if ({busy, ld_ready, core_rst} !== 3'b000) $display("FAIL load_done busy/ready/core_rst got %b want 000", {busy, ld_ready, core_rst}); else passed++;
    checks++; if (bcnt !== n + stall_n) $display("FAIL load_busy_cycles got %0d want %0d", bcnt, n + stall_n); else passed++;
  endtask

  task automatic core_write(input logic [10:0] a, input logic [15:0] d);
    @(negedge clk);
    mem_addr = a;
    mem_write = 1;
    tb_en = 1;
    tb_val = d;
    @(negedge clk);
    mem_write = 0;
    tb_en = 0;
    model[a] = d;
  endtask

  task automatic test_reset;
    #1;
    checks++; if ({core_rst, busy, ld_ready} !== 3'b100) $display("FAIL reset_outputs got %b want 100", {core_rst, busy, ld_ready}); else passed++;
    checks++; if (bus !== 16'hz && bus !== 16'h0) $display("FAIL reset_bus got %h want z", bus); else passed++;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    checks++; if ({core_rst, busy, ld_ready} !== 3'b100) $display("FAIL idle_outputs got %b want 100", {core_rst, busy, ld_ready}); else passed++;
  endtask

  task automatic test_basic_load;
    logic [15:0] exp [3];
    exp = '{16'h0FFF, 16'h0000, 16'h17FE};
    preset = '{16'h0FFF, 16'h0000, 16'h17FE};
    load(3, -1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_addr = 11'(i);
      #1;
      checks++; if (bus !== exp[i]) $display("FAIL basic_read addr %0d got %h want %h", i, bus, exp[i]); else passed++;
    end
  endtask

  task automatic test_core_write;
    logic [10:0] a [8];
    @(negedge clk);
    mem_addr = 11'h7FF;
    mem_write = 1;
    tb_en = 1;
    tb_val = 16'h0037;
    #1;
    checks++; if (bus !== 16'h0037) $display("FAIL write_bus_contention got %h want 0037", bus); else passed++;
    @(negedge clk);
    mem_write = 0;
    tb_en = 0;
    model[11'h7FF] = 16'h0037;
    #1;
    checks++; if (bus !== 16'h0037) $display("FAIL write_readback got %h want 0037", bus); else passed++;
    for (int i = 0; i < 8; i++) begin
      a[i] = 11'($urandom_range(3, 2046));
      core_write(a[i], 16'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_addr = a[i];
      #1;
      checks++; if (bus !== model[a[i]]) $display("FAIL write_rand addr %h got %h want %h", a[i], bus, model[a[i]]); else passed++;
    end
  endtask

  task automatic test_stall_load;
    load(4, 2, 2, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_addr = 11'(i);
      #1;
      checks++; if (bus !== model[i]) $display("FAIL stall_read addr %0d got %h want %h", i, bus, model[i]); else passed++;
    end
    @(negedge clk);
    mem_addr = 11'h7FF;
    #1;
    checks++; if (bus !== 16'h0037) $display("FAIL stall_untouched got %h want 0037", bus); else passed++;
  endtask

  task automatic test_reset_midload;
    @(negedge clk);
    ld_start = 1;
    ld_len = 12'd5;
    @(negedge clk);
    ld_start = 0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1;
      ld_data = i == 0 ? (16'($urandom) | 16'h8000) : 16'($urandom);
      model[i] = ld_data;
      @(negedge clk);
    end
    ld_valid = 0;
    rst = 0;
    mem_addr = 11'd0;
    #1;
    checks++; if ({core_rst, busy, ld_ready} !== 3'b100) $display("FAIL midload_reset got %b want 100", {core_rst, busy, ld_ready}); else passed++;
    checks++; if (bus !== 16'hz && bus !== 16'h0) $display("FAIL midload_bus got %h want z", bus); else passed++;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    checks++; if ({core_rst, busy} !== 2'b10) $display("FAIL midload_no_run got %b want 10", {core_rst, busy}); else passed++;
    checks++; if (bus !== 16'hz && bus !== 16'h0) $display("FAIL midload_bus_idle got %h want z", bus); else passed++;
    preset = '{16'hE000};
    load(1, -1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_addr = 11'(i);
      #1;
      checks++; if (bus !== model[i]) $display("FAIL midload_read addr %0d got %h want %h", i, bus, model[i]); else passed++;
    end
  endtask

  task automatic test_zero_len;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    mem_addr = 11'd2;
    mem_write = 1;
    tb_en = 1;
    tb_val = ~model[2];
    @(negedge clk);
    mem_write = 0;
    tb_en = 0;
    load(0, -1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_addr = 11'(i);
      #1;
      checks++; if (bus !== model[i]) $display("FAIL zero_len_read addr %0d got %h want %h", i, bus, model[i]); else passed++;
    end
  endtask

  task automatic test_reload_from_run;
    core_write(11'h400, 16'($urandom));
    load(2, -1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_addr = i == 2 ? 11'h400 : 11'(i);
      #1;
      checks++; if (bus !== model[mem_addr]) $display("FAIL reload_read addr %h got %h want %h", mem_addr, bus, model[mem_addr]); else passed++;
    end
  endtask

  task automatic test_clamp;
    logic [10:0] a [4];
    a = '{11'h000, 11'h400, 11'h7FE, 11'h7FF};
    load(12'hFFF, -1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_addr = a[i];
      #1;
      checks++; if (bus !== model[a[i]]) $display("FAIL clamp_read addr %h got %h want %h", a[i], bus, model[a[i]]); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int len;
    for (int r = 0; r < 3; r++) begin
      len = int'($urandom_range(1, 24));
      load(len, int'($urandom_range(0, len - 1)), int'($urandom_range(0, 3)), 0);
      for (int k = 0; k < 4; k++) core_write(11'($urandom_range(0, 31)), 16'($urandom));
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        mem_addr = 11'(i);
        #1;
        checks++; if (bus !== model[i]) $display("FAIL b2b_read round %0d addr %0d got %h want %h", r, i, bus, model[i]); else passed++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_load;
    test_core_write;
    test_stall_load;
    test_reset_midload;
    test_zero_len;
    test_reload_from_run;
    test_clamp;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
